// File: rtl/mcs4_rom_loader.sv
// Streams a program image into the MCS4 system ROM through its ROM_INIT port,
// or reads the ROM back and counts mismatches against the stream (verify mode).
module mcs4_rom_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 13
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              START,
  input  logic              MODE,
  input  logic              ABORT,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              ROM_INIT_ENB,
  output logic [ADDR_W-1:0] ROM_INIT_ADDR,
  output logic              ROM_INIT_RE,
  output logic              ROM_INIT_WE,
  output logic [DATA_W-1:0] ROM_INIT_WDATA,
  input  logic [DATA_W-1:0] ROM_INIT_RDATA,
  output logic              CPU_RES_N,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [CNT_W-1:0]  ERR_COUNT,
  output logic [ADDR_W-1:0] ERR_ADDR
);

  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_REQ,
    RD_WAIT,
    FIN
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  expected;
  logic [LAT_W-1:0]   lat_cnt;

  logic handshake;
  logic last_word;

  assign handshake = IN_VALID & IN_READY;
  assign last_word = (addr == LAST_ADDR);

  // FIN spends its first cycle dropping ENB (ENB itself marks that phase)
  // and the second raising DONE, so ENB covers the final strobe entirely.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state          <= IDLE;
      addr           <= '0;
      expected       <= '0;
      lat_cnt        <= '0;
      IN_READY       <= 1'b0;
      ROM_INIT_ENB   <= 1'b0;
      ROM_INIT_ADDR  <= '0;
      ROM_INIT_RE    <= 1'b0;
      ROM_INIT_WE    <= 1'b0;
      ROM_INIT_WDATA <= '0;
      CPU_RES_N      <= 1'b0;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
      ERR            <= 1'b0;
      ERR_COUNT      <= '0;
      ERR_ADDR       <= '0;
    end else if (ABORT && state != IDLE) begin
      state        <= IDLE;
      IN_READY     <= 1'b0;
      ROM_INIT_ENB <= 1'b0;
      ROM_INIT_RE  <= 1'b0;
      ROM_INIT_WE  <= 1'b0;
      CPU_RES_N    <= 1'b1;
      BUSY         <= 1'b0;
    end else begin
      ROM_INIT_WE <= 1'b0;
      ROM_INIT_RE <= 1'b0;
      case (state)
        IDLE: begin
          CPU_RES_N <= 1'b1;
          if (START) begin
            addr         <= '0;
            DONE         <= 1'b0;
            ERR          <= 1'b0;
            ERR_COUNT    <= '0;
            ERR_ADDR     <= '0;
            ROM_INIT_ENB <= 1'b1;
            CPU_RES_N    <= 1'b0;
            BUSY         <= 1'b1;
            IN_READY     <= 1'b1;
            state        <= MODE ? RD_REQ : WR;
          end
        end
        WR: begin
          if (handshake) begin
            ROM_INIT_WE    <= 1'b1;
            ROM_INIT_ADDR  <= addr;
            ROM_INIT_WDATA <= IN_DATA;
            if (last_word) begin
              IN_READY <= 1'b0;
              state    <= FIN;
            end else begin
              addr <= addr + ADDR_W'(1);
            end
          end
        end
        RD_REQ: begin
          if (handshake) begin
            expected      <= IN_DATA;
            ROM_INIT_RE   <= 1'b1;
            ROM_INIT_ADDR <= addr;
            IN_READY      <= 1'b0;
            lat_cnt       <= '0;
            state         <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (lat_cnt == LAT_W'(RD_LAT)) begin
            if (ROM_INIT_RDATA != expected) begin
              ERR <= 1'b1;
              if (ERR_COUNT != CNT_MAX) ERR_COUNT <= ERR_COUNT + CNT_W'(1);
              if (ERR_COUNT == '0) ERR_ADDR <= addr;
            end
            if (last_word) begin
              state <= FIN;
            end else begin
              addr     <= addr + ADDR_W'(1);
              IN_READY <= 1'b1;
              state    <= RD_REQ;
            end
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        FIN: begin
          if (ROM_INIT_ENB) begin
            ROM_INIT_ENB <= 1'b0;
            CPU_RES_N    <= 1'b1;
          end else begin
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcs4_rom_loader.sv
// Directed bench for mcs4_rom_loader with DEPTH=4 and a behavioural ROM that
// answers reads one cycle after RE.
module tb_mcs4_rom_loader;

  logic        CLK;
  logic        RES;
  logic        START;
  logic        MODE;
  logic        ABORT;
  logic        IN_VALID;
  logic        IN_READY;
  logic [7:0]  IN_DATA;
  logic        ROM_INIT_ENB;
  logic [11:0] ROM_INIT_ADDR;
  logic        ROM_INIT_RE;
  logic        ROM_INIT_WE;
  logic [7:0]  ROM_INIT_WDATA;
  logic [7:0]  ROM_INIT_RDATA;
  logic        CPU_RES_N;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [12:0] ERR_COUNT;
  logic [11:0] ERR_ADDR;

  int n_checks = 0;
  int n_fails  = 0;

  mcs4_rom_loader #(
    .ADDR_W(12), .DATA_W(8), .DEPTH(4), .RD_LAT(1), .CNT_W(13)
  ) dut (
    .CLK(CLK), .RES(RES), .START(START), .MODE(MODE), .ABORT(ABORT),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .ROM_INIT_ENB(ROM_INIT_ENB), .ROM_INIT_ADDR(ROM_INIT_ADDR),
    .ROM_INIT_RE(ROM_INIT_RE), .ROM_INIT_WE(ROM_INIT_WE),
    .ROM_INIT_WDATA(ROM_INIT_WDATA), .ROM_INIT_RDATA(ROM_INIT_RDATA),
    .CPU_RES_N(CPU_RES_N), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .ERR_COUNT(ERR_COUNT), .ERR_ADDR(ERR_ADDR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [7:0] rom [0:4095];
  initial ROM_INIT_RDATA = 8'h00;
  always @(posedge CLK) begin
    if (ROM_INIT_ENB && ROM_INIT_WE) rom[ROM_INIT_ADDR] <= ROM_INIT_WDATA;
    if (ROM_INIT_ENB && ROM_INIT_RE) ROM_INIT_RDATA <= rom[ROM_INIT_ADDR];
  end

  // Strobe log; cycle stamps share one reference so spacings can be checked.
  int          cyc = 0;
  logic        done_q;
  int          done_cyc = 0;
  int          bad_resn = 0;
  int          bad_enb  = 0;
  logic [11:0] we_addr [$];
  logic [7:0]  we_data [$];
  int          we_cyc  [$];
  int          re_cyc  [$];

  always @(posedge CLK) begin
    cyc    <= cyc + 1;
    done_q <= DONE;
    if (ROM_INIT_WE) begin
      we_addr.push_back(ROM_INIT_ADDR);
      we_data.push_back(ROM_INIT_WDATA);
      we_cyc.push_back(cyc);
    end
    if (ROM_INIT_RE) re_cyc.push_back(cyc);
    if (DONE && !done_q) done_cyc <= cyc;
    if (ROM_INIT_ENB && CPU_RES_N) bad_resn <= bad_resn + 1;
    if ((ROM_INIT_WE || ROM_INIT_RE) && !ROM_INIT_ENB) bad_enb <= bad_enb + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Starts a pass and streams img (byte 0 first); abort_after >= 0 raises
  // ABORT, together with a valid word, once that many words were accepted.
  task automatic applyStimulus(input logic mode, input logic [31:0] img,
                               input int gap_cycles, input int abort_after);
    bit accepted;
    @(negedge CLK);
    START = 1'b1;
    MODE  = mode;
    @(negedge CLK);
    START = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0 && gap_cycles > 0) begin
        IN_VALID = 1'b0;
        repeat (gap_cycles) @(negedge CLK);
      end
      IN_VALID = 1'b1;
      IN_DATA  = img[8*i +: 8];
      if (i == abort_after) begin
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT    = 1'b0;
        IN_VALID = 1'b0;
        return;
      end
      accepted = 1'b0;
      for (int t = 0; t < 20 && !accepted; t++) begin
        if (IN_READY) accepted = 1'b1;
        @(negedge CLK);
      end
      if (!accepted) checkOutput($sformatf("handshake_timeout_w%0d", i), 32'd0, 32'd1);
    end
    IN_VALID = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int t;
    t = 0;
    while (!DONE && t < 50) begin
      @(negedge CLK);
      t++;
    end
    checkOutput(tag, 32'(DONE), 32'd1);
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int we0;
    int re0;
    int br0;
    int be0;
    logic [31:0] img;
    logic [31:0] img2;
    bit accepted;

    RES = 1'b0; START = 1'b0; MODE = 1'b0; ABORT = 1'b0;
    IN_VALID = 1'b0; IN_DATA = 8'h00;
    #1 RES = 1'b1;
    #2;
    checkOutput("rst_enb",      32'(ROM_INIT_ENB),  32'd0);
    checkOutput("rst_in_ready", 32'(IN_READY),      32'd0);
    checkOutput("rst_we",       32'(ROM_INIT_WE),   32'd0);
    checkOutput("rst_re",       32'(ROM_INIT_RE),   32'd0);
    checkOutput("rst_addr",     32'(ROM_INIT_ADDR), 32'd0);
    checkOutput("rst_cpu_res_n",32'(CPU_RES_N),     32'd0);
    checkOutput("rst_busy",     32'(BUSY),          32'd0);
    checkOutput("rst_done",     32'(DONE),          32'd0);
    checkOutput("rst_err_count",32'(ERR_COUNT),     32'd0);
    checkOutput("rst_err_addr", 32'(ERR_ADDR),      32'd0);
    @(negedge CLK);
    RES = 1'b0;
    @(negedge CLK);
    checkOutput("idle_cpu_res_n", 32'(CPU_RES_N), 32'd1);

    $display("[TB] write pass, back-to-back stream");
    img = 32'h44332211;
    we0 = we_addr.size(); br0 = bad_resn; be0 = bad_enb;
    applyStimulus(1'b0, img, 0, -1);
    waitDone("t1_done");
    checkOutput("t1_we_count", 32'(we_addr.size() - we0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t1_we_addr%0d", i), 32'(we_addr[we0+i]), 32'(i));
      checkOutput($sformatf("t1_we_data%0d", i), 32'(we_data[we0+i]), 32'(img[8*i +: 8]));
      checkOutput($sformatf("t1_we_cyc%0d", i), 32'(we_cyc[we0+i] - we_cyc[we0]), 32'(i));
    end
    checkOutput("t1_done_delay", 32'(done_cyc - we_cyc[we0+3]), 32'd2);
    checkOutput("t1_busy",       32'(BUSY), 32'd0);
    checkOutput("t1_enb",        32'(ROM_INIT_ENB), 32'd0);
    checkOutput("t1_cpu_res_n",  32'(CPU_RES_N), 32'd1);
    checkOutput("t1_resn_while_enb", 32'(bad_resn - br0), 32'd0);
    checkOutput("t1_strobe_wo_enb",  32'(bad_enb - be0), 32'd0);

    $display("[TB] verify pass, matching stream");
    re0 = re_cyc.size(); we0 = we_addr.size();
    applyStimulus(1'b1, img, 0, -1);
    waitDone("t2_done");
    checkOutput("t2_re_count", 32'(re_cyc.size() - re0), 32'd4);
    for (int i = 1; i < 4; i++)
      checkOutput($sformatf("t2_re_spacing%0d", i), 32'(re_cyc[re0+i] - re_cyc[re0+i-1]), 32'd3);
    checkOutput("t2_no_we",    32'(we_addr.size() - we0), 32'd0);
    checkOutput("t2_err",      32'(ERR), 32'd0);
    checkOutput("t2_err_count",32'(ERR_COUNT), 32'd0);

    $display("[TB] verify pass, two corrupted words");
    applyStimulus(1'b1, 32'h00339911, 0, -1);
    waitDone("t3_done");
    checkOutput("t3_err",       32'(ERR), 32'd1);
    checkOutput("t3_err_count", 32'(ERR_COUNT), 32'd2);
    checkOutput("t3_err_addr",  32'(ERR_ADDR), 32'd1);
    checkOutput("t3_addr_hold", 32'(ROM_INIT_ADDR), 32'd3);

    $display("[TB] write pass, IN_VALID every other cycle");
    img2 = 32'hD4C3B2A1;
    we0 = we_addr.size();
    applyStimulus(1'b0, img2, 1, -1);
    waitDone("t4_done");
    checkOutput("t4_we_count", 32'(we_addr.size() - we0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t4_we_addr%0d", i), 32'(we_addr[we0+i]), 32'(i));
      checkOutput($sformatf("t4_we_data%0d", i), 32'(we_data[we0+i]), 32'(img2[8*i +: 8]));
    end
    applyStimulus(1'b1, img2, 0, -1);
    waitDone("t4_verify_done");
    checkOutput("t4_verify_err_count", 32'(ERR_COUNT), 32'd0);

    $display("[TB] abort after second handshake");
    we0 = we_addr.size();
    applyStimulus(1'b0, img, 0, 2);
    checkOutput("t5_enb",      32'(ROM_INIT_ENB), 32'd0);
    checkOutput("t5_busy",     32'(BUSY), 32'd0);
    checkOutput("t5_done",     32'(DONE), 32'd0);
    checkOutput("t5_in_ready", 32'(IN_READY), 32'd0);
    repeat (3) @(negedge CLK);
    checkOutput("t5_we_count", 32'(we_addr.size() - we0), 32'd2);
    checkOutput("t5_we_addr0", 32'(we_addr[we0]),   32'd0);
    checkOutput("t5_we_addr1", 32'(we_addr[we0+1]), 32'd1);
    we0 = we_addr.size();
    applyStimulus(1'b0, img, 0, -1);
    waitDone("t5_restart_done");
    checkOutput("t5_restart_we_count", 32'(we_addr.size() - we0), 32'd4);

    $display("[TB] reset during RD_WAIT");
    @(negedge CLK);
    START = 1'b1; MODE = 1'b1;
    @(negedge CLK);
    START = 1'b0; IN_VALID = 1'b1; IN_DATA = 8'h11;
    accepted = 1'b0;
    for (int t = 0; t < 20 && !accepted; t++) begin
      if (IN_READY) accepted = 1'b1;
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
    checkOutput("t6_re_before_reset", 32'(ROM_INIT_RE), 32'd1);
    #2 RES = 1'b1;
    #1;
    checkOutput("t6_re",        32'(ROM_INIT_RE),  32'd0);
    checkOutput("t6_enb",       32'(ROM_INIT_ENB), 32'd0);
    checkOutput("t6_busy",      32'(BUSY),         32'd0);
    checkOutput("t6_cpu_res_n", 32'(CPU_RES_N),    32'd0);
    checkOutput("t6_in_ready",  32'(IN_READY),     32'd0);
    checkOutput("t6_addr",      32'(ROM_INIT_ADDR),32'd0);
    repeat (2) @(negedge CLK);
    RES = 1'b0;
    re0 = re_cyc.size();
    repeat (8) @(negedge CLK);
    checkOutput("t6_no_re_after", 32'(re_cyc.size() - re0), 32'd0);
    checkOutput("t6_idle_enb",    32'(ROM_INIT_ENB), 32'd0);
    checkOutput("t6_idle_cpu_res_n", 32'(CPU_RES_N), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
